// File: rtl/muldiv_sequencer.sv
// Iterative 32-step multiply / restoring-divide sequencer; sole writer of the HI/LO pair.
// MTHI/MTLO pass straight through to the write ports while idle.
module muldiv_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  MulDivOp,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        MtHi,
    input  logic        MtLo,
    input  logic [31:0] MtData,
    input  logic        IdHiLoUse,
    output logic [31:0] HiRe,
    output logic [31:0] LoRe,
    output logic        WEHI,
    output logic        WELO,
    output logic        Busy,
    output logic        Stall
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] b_q;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        wr_q;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] acc_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        mt_hi;
    logic        mt_lo;

    // acc holds {upper partial product, multiplier} for multiply and {rem, quo} for divide.
    always_comb begin
        is_signed = ~MulDivOp[0];
        a_neg     = is_signed & OpA[31];
        b_neg     = is_signed & OpB[31];
        a_mag     = a_neg ? -OpA : OpA;
        b_mag     = b_neg ? -OpB : OpB;

        mul_sum   = {1'b0, acc[63:32]} + {1'b0, b_q};
        div_trial = acc[63:31] - {1'b0, b_q};

        if (is_div)
            acc_next = div_trial[32] ? {acc[62:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};
        else
            acc_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

        prod_fix = neg_res ? -acc_next : acc_next;
        // A zero divisor leaves quo all-ones and rem = |OpA|, so only the quotient needs overriding.
        quo_fix  = div_zero ? 32'hFFFF_FFFF
                            : (neg_res ? -acc_next[31:0] : acc_next[31:0]);
        rem_fix  = neg_rem ? -acc_next[63:32] : acc_next[63:32];

        mt_hi    = MtHi & ~Start & (state == IDLE);
        mt_lo    = MtLo & ~Start & (state == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            acc      <= 64'd0;
            b_q      <= 32'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_q <= 1'b0;
                    if (Start) begin
                        is_div   <= MulDivOp[1];
                        acc      <= {32'd0, a_mag};
                        b_q      <= b_mag;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= MulDivOp[1] & (OpB == 32'd0);
                        cnt      <= 6'd0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= DONE;
                        wr_q  <= 1'b1;
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                DONE: begin
                    wr_q  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        WEHI  = wr_q | mt_hi;
        WELO  = wr_q | mt_lo;
        HiRe  = wr_q ? hi_q : (mt_hi ? MtData : 32'd0);
        LoRe  = wr_q ? lo_q : (mt_lo ? MtData : 32'd0);
        Busy  = (state != IDLE) | Start;
        Stall = IdHiLoUse & Busy;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table through a result scoreboard,
// plus hand-written stall, MT pass-through and mid-operation reset sequences.
module tb_muldiv_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  MulDivOp;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        MtHi;
    logic        MtLo;
    logic [31:0] MtData;
    logic        IdHiLoUse;
    logic [31:0] HiRe;
    logic [31:0] LoRe;
    logic        WEHI;
    logic        WELO;
    logic        Busy;
    logic        Stall;

    muldiv_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .MulDivOp  (MulDivOp),
        .OpA       (OpA),
        .OpB       (OpB),
        .MtHi      (MtHi),
        .MtLo      (MtLo),
        .MtData    (MtData),
        .IdHiLoUse (IdHiLoUse),
        .HiRe      (HiRe),
        .LoRe      (LoRe),
        .WEHI      (WEHI),
        .WELO      (WELO),
        .Busy      (Busy),
        .Stall     (Stall)
    );

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb[$];
    vec_t vecs[15];
    int   checks   = 0;
    int   failures = 0;
    logic pending;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Protocol rules the pipeline guarantees; the bench must never break them.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pending <= 1'b0;
        end else begin
            assert (!(Start && (MtHi || MtLo))) else $error("Start with MTHI/MTLO");
            assert (!(Start && pending)) else $error("Start while operation in flight");
            if (Start)
                pending <= 1'b1;
            else if (WEHI && WELO)
                pending <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Start at cycle t, expect the write exactly at t+33 and Busy low at t+34.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input string name);
        int   n;
        res_t e;
        @(posedge Clk); #1;
        Start    = 1'b1;
        MulDivOp = op;
        OpA      = a;
        OpB      = b;
        sb.push_back({hi, lo});
        #1;
        check({name, " busy_at_start"}, Busy, 1);
        @(posedge Clk); #1;
        Start = 1'b0;
        OpA   = $urandom;
        OpB   = $urandom;
        n     = 1;
        while (!WEHI && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
        check({name, " latency"}, n, 33);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({name, " welo"}, WELO, 1);
        check({name, " hi"}, HiRe, e.hi);
        check({name, " lo"}, LoRe, e.lo);
        @(posedge Clk); #1;
        check({name, " busy_after"}, Busy, 0);
        check({name, " we_after"}, {WEHI, WELO}, 0);
    endtask

    initial begin
        res_t e;
        logic saw_we;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5"};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"};
        vecs[5]  = '{OP_DIV,   32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF, "div_by_zero"};
        vecs[6]  = '{OP_DIV,   32'hFFFFFB2E, 32'd0,        32'hFFFFFB2E, 32'hFFFFFFFF, "div_neg_by_zero"};
        vecs[7]  = '{OP_DIVU,  32'h80000005, 32'd0,        32'h80000005, 32'hFFFFFFFF, "divu_by_zero"};
        vecs[8]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mult_maxpos"};
        vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_neg2"};
        vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minneg"};
        vecs[11] = '{OP_MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0,        "multu_carry"};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, "divu_max_10"};
        vecs[13] = '{OP_MULT,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, "mult_neg1"};
        vecs[14] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        "div_neg8_neg3"};

        Reset     = 1'b1;
        Start     = 1'b0;
        MulDivOp  = 2'b00;
        OpA       = 32'd0;
        OpB       = 32'd0;
        MtHi      = 1'b0;
        MtLo      = 1'b0;
        MtData    = 32'd0;
        IdHiLoUse = 1'b1;
        #1;
        check("reset_outputs", {HiRe, LoRe, WEHI, WELO, Busy, Stall}, 0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset     = 1'b0;
        IdHiLoUse = 1'b0;

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

        // MFHI enters ID at t+2 and must be held through t+33.
        @(posedge Clk); #1;
        Start    = 1'b1;
        MulDivOp = OP_DIVU;
        OpA      = 32'd100;
        OpB      = 32'd7;
        sb.push_back({32'd2, 32'd14});
        #1;
        check("stall_t_no_use", Stall, 0);
        for (int c = 1; c <= 34; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            if (c == 2) IdHiLoUse = 1'b1;
            #1;
            if (c >= 2 && c <= 33) check($sformatf("stall_t+%0d", c), Stall, 1);
            if (c == 33) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                check("stall_op_we", {WEHI, WELO}, 2'b11);
                check("stall_op_result", {HiRe, LoRe}, e);
            end
            if (c == 34) check("stall_released", Stall, 0);
        end

        // MT writes are combinational and never stall while idle.
        MtLo   = 1'b1;
        MtData = 32'hA5A5A5A5;
        #1;
        check("mtlo_we", {WEHI, WELO}, 2'b01);
        check("mtlo_data", LoRe, 32'hA5A5A5A5);
        check("mtlo_stall", Stall, 0);
        @(posedge Clk); #1;
        MtLo   = 1'b0;
        MtHi   = 1'b1;
        MtData = 32'h5A5A0001;
        #1;
        check("mthi_we", {WEHI, WELO}, 2'b10);
        check("mthi_data", HiRe, 32'h5A5A0001);
        @(posedge Clk); #1;
        MtHi      = 1'b0;
        IdHiLoUse = 1'b0;

        // Reset during RUN iteration 10 aborts the operation without any write.
        @(posedge Clk); #1;
        Start    = 1'b1;
        MulDivOp = OP_MULTU;
        OpA      = 32'h12345678;
        OpB      = 32'h9ABCDEF0;
        @(posedge Clk); #1;
        Start     = 1'b0;
        IdHiLoUse = 1'b1;
        saw_we    = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            @(posedge Clk); #1;
            saw_we = saw_we | WEHI | WELO;
        end
        Reset = 1'b1;
        #1;
        check("abort_outputs", {HiRe, LoRe, WEHI, WELO, Busy, Stall}, 0);
        @(posedge Clk); #1;
        Reset     = 1'b0;
        IdHiLoUse = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clk); #1;
            saw_we = saw_we | WEHI | WELO;
        end
        check("abort_no_write", saw_we, 0);

        run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_reset");

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
